// File: rtl/spraid_wb_initiator.sv
// rtl/spraid_wb_initiator.sv - Wishbone pipelined-mode block initiator for wb_spraid
//
// Accepts a block command (first address, word count, direction) and runs one
// single-word pipelined Wishbone transaction per word, holding CYC for the
// whole block. Write data arrives on the wdata stream; read data leaves on
// the rdata stream.
//
// Optional feature macro: SPRAID_WBI_TIMEOUT_EN builds a per-word watchdog
// that aborts the block after TIMEOUT cycles spent in REQ + WAIT_ACK.
//
// Ports:
//   wb_clk_i, wb_rst_i            clock, asynchronous active-high reset
//   cmd_valid/cmd_ready           command handshake
//   cmd_we, cmd_addr, cmd_len     direction, first word address, count (0 = 256)
//   wdata_valid/wdata_ready/wdata write data stream in
//   rdata_valid/rdata_ready/rdata read data stream out
//   done, err                     one-cycle block completion / abort pulses
//   err_code                      01 bus error, 10 timeout; held until next command
//   words_left                    words remaining in the current block
//   wbm_*                         Wishbone pipelined master port
module spraid_wb_initiator #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_addr,
  input  logic [7:0]  cmd_len,
  input  logic        wdata_valid,
  output logic        wdata_ready,
  input  logic [31:0] wdata,
  output logic        rdata_valid,
  input  logic        rdata_ready,
  output logic [31:0] rdata,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [8:0]  words_left,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_stall_i,
  input  logic        wbm_err_i,
  input  logic        wbm_rty_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_REQ,
    S_WAIT_ACK,
    S_RDATA,
    S_DONE,
    S_ERR
  } state_t;

  state_t state;
  logic   last_word;

  assign last_word = (words_left == 9'd1);

`ifdef SPRAID_WBI_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  logic        tmo_hit;

  // Counter sits at zero outside REQ/WAIT_ACK, so every entry to REQ from
  // IDLE, FETCH or RDATA starts a fresh window; a retry also restarts it.
  assign tmo_hit = (tmo_cnt == 16'(TIMEOUT - 1));

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      tmo_cnt <= 16'd0;
    end else if ((state != S_REQ) && (state != S_WAIT_ACK)) begin
      tmo_cnt <= 16'd0;
    end else if ((state == S_WAIT_ACK) && wbm_rty_i && !wbm_err_i) begin
      tmo_cnt <= 16'd0;
    end else begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end
  end
`else
  // TIMEOUT only matters when the watchdog is built.
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
`endif

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state       <= S_IDLE;
      cmd_ready   <= 1'b1;
      wdata_ready <= 1'b0;
      rdata_valid <= 1'b0;
      rdata       <= 32'd0;
      done        <= 1'b0;
      err         <= 1'b0;
      err_code    <= 2'b00;
      words_left  <= 9'd0;
      wbm_cyc_o   <= 1'b0;
      wbm_stb_o   <= 1'b0;
      wbm_we_o    <= 1'b0;
      wbm_adr_o   <= 32'd0;
      wbm_dat_o   <= 32'd0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            cmd_ready  <= 1'b0;
            wbm_cyc_o  <= 1'b1;
            wbm_we_o   <= cmd_we;
            wbm_adr_o  <= cmd_addr;
            words_left <= (cmd_len == 8'd0) ? 9'd256 : {1'b0, cmd_len};
            err_code   <= 2'b00;
            if (cmd_we) begin
              wdata_ready <= 1'b1;
              state       <= S_FETCH;
            end else begin
              wbm_stb_o <= 1'b1;
              state     <= S_REQ;
            end
          end
        end

        S_FETCH: begin
          if (wdata_valid) begin
            wbm_dat_o   <= wdata;
            wdata_ready <= 1'b0;
            wbm_stb_o   <= 1'b1;
            state       <= S_REQ;
          end
        end

        S_REQ: begin
`ifdef SPRAID_WBI_TIMEOUT_EN
          if (tmo_hit) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            err       <= 1'b1;
            err_code  <= 2'b10;
            state     <= S_ERR;
          end else
`endif
          if (!wbm_stall_i) begin
            wbm_stb_o <= 1'b0;
            state     <= S_WAIT_ACK;
          end
        end

        // Bus responses beat a watchdog expiry in the same cycle.
        S_WAIT_ACK: begin
          if (wbm_err_i) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            err       <= 1'b1;
            err_code  <= 2'b01;
            state     <= S_ERR;
          end else if (wbm_rty_i) begin
            wbm_stb_o <= 1'b1;
            state     <= S_REQ;
          end else if (wbm_ack_i) begin
            if (wbm_we_o) begin
              words_left <= words_left - 9'd1;
              wbm_adr_o  <= wbm_adr_o + 32'd1;
              if (last_word) begin
                wbm_cyc_o <= 1'b0;
                done      <= 1'b1;
                state     <= S_DONE;
              end else begin
                wdata_ready <= 1'b1;
                state       <= S_FETCH;
              end
            end else begin
              rdata       <= wbm_dat_i;
              rdata_valid <= 1'b1;
              state       <= S_RDATA;
            end
          end
`ifdef SPRAID_WBI_TIMEOUT_EN
          else if (tmo_hit) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            err       <= 1'b1;
            err_code  <= 2'b10;
            state     <= S_ERR;
          end
`endif
        end

        S_RDATA: begin
          if (rdata_ready) begin
            rdata_valid <= 1'b0;
            words_left  <= words_left - 9'd1;
            wbm_adr_o   <= wbm_adr_o + 32'd1;
            if (last_word) begin
              wbm_cyc_o <= 1'b0;
              done      <= 1'b1;
              state     <= S_DONE;
            end else begin
              wbm_stb_o <= 1'b1;
              state     <= S_REQ;
            end
          end
        end

        S_DONE, S_ERR: begin
          cmd_ready <= 1'b1;
          state     <= S_IDLE;
        end

        default: begin
          cmd_ready <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spraid_wb_initiator.sv
// tb/tb_spraid_wb_initiator.sv - directed scoreboard bench for spraid_wb_initiator
`timescale 1ns/1ps
module tb_spraid_wb_initiator;

`ifdef SPRAID_WBI_TIMEOUT_EN
  localparam int unsigned TMO = 8;
`else
  localparam int unsigned TMO = 1024;
`endif

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_addr = 32'd0;
  logic [7:0]  cmd_len = 8'd0;
  logic        wdata_valid = 1'b0;
  logic        wdata_ready;
  logic [31:0] wdata = 32'd0;
  logic        rdata_valid;
  logic        rdata_ready = 1'b0;
  logic [31:0] rdata;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic [8:0]  words_left;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i, wbm_stall_i, wbm_err_i, wbm_rty_i;

  spraid_wb_initiator #(.TIMEOUT(TMO)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
    .done(done), .err(err), .err_code(err_code), .words_left(words_left),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i),
    .wbm_ack_i(wbm_ack_i), .wbm_stall_i(wbm_stall_i), .wbm_err_i(wbm_err_i),
    .wbm_rty_i(wbm_rty_i)
  );

  initial forever #5 wb_clk_i = ~wb_clk_i;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } bus_t;

  bus_t        bus_q[$];
  logic [31:0] rd_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  int stall_left     = 0;
  bit rty_pending    = 1'b0;
  int err_word       = 0;
  bit never_ack      = 1'b0;
  bit late_ack       = 1'b0;
  bit pending        = 1'b0;
  bit prev_stall_stb = 1'b0;
  int req_n          = 0;

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A00_00A5;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Slave model: stalls, retries, errors on request; checks every accepted
  // request against the front of the bus scoreboard.
  initial begin
    wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_rty_i = 1'b0;
    wbm_stall_i = 1'b0; wbm_dat_i = 32'd0;
    forever begin
      @(negedge wb_clk_i);
      wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_rty_i = 1'b0;
      if (prev_stall_stb) check("stb_held_in_stall", wbm_stb_o, 1);
      prev_stall_stb = 1'b0;
      if (late_ack) begin
        wbm_ack_i = 1'b1;
        late_ack  = 1'b0;
      end
      if (pending) begin
        pending = 1'b0;
        if (never_ack) begin
          wbm_ack_i = 1'b0;
        end else if (err_word == req_n) begin
          wbm_err_i = 1'b1;
          wbm_ack_i = 1'b1;
        end else if (rty_pending) begin
          wbm_rty_i   = 1'b1;
          rty_pending = 1'b0;
        end else begin
          wbm_ack_i = 1'b1;
          wbm_dat_i = rd_model(wbm_adr_o);
          if (bus_q.size() != 0) void'(bus_q.pop_front());
        end
      end
      wbm_stall_i = 1'b0;
      if (wbm_cyc_o && wbm_stb_o) begin
        if (stall_left > 0) begin
          wbm_stall_i    = 1'b1;
          stall_left--;
          prev_stall_stb = 1'b1;
        end else begin
          pending = 1'b1;
          req_n++;
          check("bus_req_expected", (bus_q.size() != 0), 1);
          if (bus_q.size() != 0) begin
            check("bus_we", wbm_we_o, bus_q[0].we);
            check("bus_adr", wbm_adr_o, bus_q[0].adr);
            if (bus_q[0].we) check("bus_dat", wbm_dat_o, bus_q[0].dat);
          end
        end
      end
    end
  end

  task automatic flush();
    #1;
    bus_q.delete();
    rd_q.delete();
    pending = 1'b0;
    prev_stall_stb = 1'b0;
    req_n = 0;
  endtask

  // Issues one command and services the data streams until done/err or the
  // cycle budget runs out. end_cyc is the loop index at which done/err shows.
  task automatic run_block(input bit we, input logic [31:0] addr, input logic [7:0] len,
                           input logic [31:0] wbase, input int rr_hold, input int budget,
                           output int n_done, output int n_err, output int cyc_lows,
                           output int end_cyc);
    int n, wi, rr;
    n = (len == 8'd0) ? 256 : int'(len);
    n_done = 0; n_err = 0; cyc_lows = 0; end_cyc = -1; wi = 0; rr = rr_hold;
    if (!we)
      for (int i = 0; i < n; i++) begin
        bus_q.push_back('{we: 1'b0, adr: addr + 32'(i), dat: 32'd0});
        rd_q.push_back(rd_model(addr + 32'(i)));
      end
    @(negedge wb_clk_i);
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_len = len;
    for (int c = 0; c < budget; c++) begin
      @(negedge wb_clk_i);
      cmd_valid = 1'b0;
      if (done) n_done++;
      if (err) n_err++;
      if (done || err) begin
        end_cyc = c;
        break;
      end
      if (!wbm_cyc_o) cyc_lows++;
      if (we) begin
        wdata_valid = (wi < n);
        wdata = wbase * 32'(wi + 1);
        if (wdata_valid && wdata_ready) begin
          bus_q.push_back('{we: 1'b1, adr: addr + 32'(wi), dat: wdata});
          wi++;
        end
      end else if (rdata_valid) begin
        check("rdata_expected", (rd_q.size() != 0), 1);
        if (rd_q.size() != 0) check("rdata", rdata, rd_q[0]);
        if (rr > 0) begin
          rdata_ready = 1'b0;
          rr--;
        end else begin
          rdata_ready = 1'b1;
          if (rd_q.size() != 0) void'(rd_q.pop_front());
        end
      end else begin
        rdata_ready = 1'b0;
      end
    end
    wdata_valid = 1'b0;
    rdata_ready = 1'b0;
  endtask

  int nd, ne, cl, ec;

  initial begin
    // Reset state
    repeat (3) @(negedge wb_clk_i);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_cyc", wbm_cyc_o, 0);
    check("rst_stb", wbm_stb_o, 0);
    check("rst_words_left", words_left, 0);
    check("rst_adr", wbm_adr_o, 0);
    check("rst_rdata", rdata, 0);
    wb_rst_i = 1'b0;

    // Write len=4, no stall, ack +1
    run_block(1'b1, 32'h3000_0000, 8'd4, 32'h11, 0, 40, nd, ne, cl, ec);
    check("w4_done", nd, 1);
    check("w4_err", ne, 0);
    check("w4_cyc_continuous", cl, 0);
    check("w4_done_cycle", ec, 12);
    check("w4_words_left", words_left, 0);
    check("w4_cyc_low_at_done", wbm_cyc_o, 0);
    check("w4_bus_q_empty", bus_q.size(), 0);
    @(negedge wb_clk_i);
    check("w4_done_one_cycle", done, 0);
    check("w4_cmd_ready", cmd_ready, 1);
    flush();

    // Read len=2, stall 5 cycles, rdata_ready low 3 cycles
    stall_left = 5;
    run_block(1'b0, 32'h3000_0010, 8'd2, 32'h0, 3, 40, nd, ne, cl, ec);
    check("r2_done", nd, 1);
    check("r2_done_cycle", ec, 14);
    check("r2_stall_consumed", stall_left, 0);
    check("r2_cyc_continuous", cl, 0);
    check("r2_rd_q_empty", rd_q.size(), 0);
    check("r2_bus_q_empty", bus_q.size(), 0);
    flush();

    // Write len=1 with one retry
    rty_pending = 1'b1;
    run_block(1'b1, 32'h3000_0100, 8'd1, 32'hDEAD_0001, 0, 20, nd, ne, cl, ec);
    check("rty_done", nd, 1);
    check("rty_no_err", ne, 0);
    check("rty_req_count", req_n, 2);
    check("rty_done_cycle", ec, 5);
    check("rty_bus_q_empty", bus_q.size(), 0);
    flush();

    // Read len=3, err+ack on word 2
    err_word = 2;
    run_block(1'b0, 32'h3000_0200, 8'd3, 32'h0, 0, 20, nd, ne, cl, ec);
    check("err_pulse", ne, 1);
    check("err_no_done", nd, 0);
    check("err_cycle", ec, 5);
    check("err_code_bus", err_code, 2'b01);
    check("err_cyc_low", wbm_cyc_o, 0);
    check("err_stb_low", wbm_stb_o, 0);
    check("err_words_left", words_left, 2);
    check("err_unissued_words", bus_q.size(), 2);
    @(negedge wb_clk_i);
    check("err_one_cycle", err, 0);
    check("err_code_held", err_code, 2'b01);
    check("err_cmd_ready", cmd_ready, 1);
    err_word = 0;
    flush();

    // Stray ack while idle is ignored
    late_ack = 1'b1;
    repeat (3) @(negedge wb_clk_i);
    check("idle_ack_no_done", done, 0);
    check("idle_ack_no_err", err, 0);
    check("idle_ack_cmd_ready", cmd_ready, 1);
    flush();

`ifdef SPRAID_WBI_TIMEOUT_EN
    // Slave never acks: abort TIMEOUT cycles after entering REQ
    never_ack = 1'b1;
    run_block(1'b0, 32'h0000_0040, 8'd1, 32'h0, 0, 30, nd, ne, cl, ec);
    check("tmo_err", ne, 1);
    check("tmo_cycle", ec, 8);
    check("tmo_code", err_code, 2'b10);
    check("tmo_cyc_low", wbm_cyc_o, 0);
    never_ack = 1'b0;
    late_ack = 1'b1;
    repeat (3) @(negedge wb_clk_i);
    check("tmo_late_ack_no_done", done, 0);
    check("tmo_code_held", err_code, 2'b10);
    check("tmo_cmd_ready", cmd_ready, 1);
    flush();
`endif

    // Read 256 words from 0xFFFFFFFF, address wraps to 0
    run_block(1'b0, 32'hFFFF_FFFF, 8'd0, 32'h0, 0, 800, nd, ne, cl, ec);
    check("w256_done", nd, 1);
    check("w256_done_cycle", ec, 768);
    check("w256_words_left", words_left, 0);
    check("w256_cyc_continuous", cl, 0);
    check("w256_rd_q_empty", rd_q.size(), 0);
    check("w256_bus_q_empty", bus_q.size(), 0);
    flush();

    // Reset mid-block
    run_block(1'b0, 32'h0000_0050, 8'd8, 32'h0, 0, 7, nd, ne, cl, ec);
    check("midrst_in_block", wbm_cyc_o, 1);
    #2 wb_rst_i = 1'b1;
    #1;
    check("midrst_cyc", wbm_cyc_o, 0);
    check("midrst_stb", wbm_stb_o, 0);
    check("midrst_cmd_ready", cmd_ready, 1);
    check("midrst_words_left", words_left, 0);
    check("midrst_adr", wbm_adr_o, 0);
    check("midrst_rdata_valid", rdata_valid, 0);
    check("midrst_rdata", rdata, 0);
    repeat (2) @(negedge wb_clk_i);
    check("midrst_no_done", done, 0);
    check("midrst_no_err", err, 0);
    wb_rst_i = 1'b0;
    flush();

    // Recovery after reset
    run_block(1'b1, 32'h0000_0060, 8'd2, 32'h1000, 0, 20, nd, ne, cl, ec);
    check("post_rst_done", nd, 1);
    check("post_rst_done_cycle", ec, 6);
    check("post_rst_bus_q_empty", bus_q.size(), 0);
    flush();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
